accum_seq_ctrl: RTL

ACCUM_SEQ_CTRL -- requirements
Module: accum_seq_ctrl

---
 rtl/accum_seq_ctrl_pkg.sv | 21 ++
 rtl/accum_seq_ctrl_dp.sv | 35 +++
 rtl/accum_seq_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/accum_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// accum_seq_ctrl_pkg
//   Shared definitions for the accumulating sequence controller:
//     - default operand/sum width (DEF_N) and operand-count width (DEF_CW)
//     - control state encoding for the run FSM (IDLE / ACC / DONE)
// ---------------------------------------------------------------------------
package accum_seq_ctrl_pkg;

  localparam int DEF_N  = 8;
  localparam int DEF_CW = 4;

  // IDLE : waiting for start, sum/flags hold their last values
  // ACC  : accepting operands until the remaining count is exhausted
  // DONE : single-cycle completion state that drives the done pulse
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : accum_seq_ctrl_pkg

// File: rtl/accum_seq_ctrl_dp.sv
// ---------------------------------------------------------------------------
// accum_dp
//   Combinational add-and-flag datapath of the accumulator.
//   Ports:
//     a      in  N  new operand
//     b      in  N  current running sum
//     cin    in  1  carry-in (the controller ties it to 0)
//     sum    out N  (a + b + cin) mod 2^N
//     carry  out 1  unsigned carry-out of the N-bit add
//     ovf    out 1  two's complement overflow of the N-bit add
// ---------------------------------------------------------------------------
module accum_dp
  import accum_seq_ctrl_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         carry,
  output logic         ovf
);

  // One extra bit on the adder captures the unsigned carry-out directly.
  logic [N:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  assign sum      = full_sum[N-1:0];
  assign carry    = full_sum[N];

  // Signed overflow: both operands share a sign but the result does not.
  assign ovf = (a[N-1] == b[N-1]) && (full_sum[N-1] != a[N-1]);

endmodule : accum_dp

// File: rtl/accum_seq_ctrl.sv
// ---------------------------------------------------------------------------
// accum_seq_ctrl
//   Accumulates a run of `len` operands into a registered N-bit sum, tracking
//   sticky unsigned-carry and signed-overflow flags, and pulses done for one
//   cycle when the run completes.
//   Ports:
//     clk         in  1   clock, all state changes on its rising edge
//     aclr_n      in  1   asynchronous active-low reset
//     start       in  1   begin a run (only honoured in IDLE)
//     len         in  CW  operand count for the run, sampled with start
//     abort       in  1   synchronous cancel of the current run
//     in_data     in  N   operand
//     in_valid    in  1   in_data is valid
//     in_ready    out 1   an operand is accepted this cycle when in_valid
//     sum         out N   registered running sum
//     carry_flag  out 1   sticky unsigned carry-out during the run
//     ovf_flag    out 1   sticky signed overflow during the run
//     done        out 1   one-cycle completion pulse
//     busy        out 1   high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module accum_seq_ctrl
  import accum_seq_ctrl_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          aclr_n,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          abort,
  input  logic [N-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [N-1:0]  sum,
  output logic          carry_flag,
  output logic          ovf_flag,
  output logic          done,
  output logic          busy
);

  state_t        state_reg, state_next;
  logic [CW-1:0] remaining_reg, remaining_next;
  logic [N-1:0]  sum_reg, sum_next;
  logic          carry_reg, carry_next;
  logic          ovf_reg, ovf_next;

  logic          beat;
  logic [N-1:0]  dp_sum;
  logic          dp_carry;
  logic          dp_ovf;

  // -------------------------------------------------------------------------
  // Datapath: next sum and per-beat flags from the current sum and operand.
  // -------------------------------------------------------------------------
  accum_dp #(
    .N (N)
  ) u_dp (
    .a     (in_data),
    .b     (sum_reg),
    .cin   (1'b0),
    .sum   (dp_sum),
    .carry (dp_carry),
    .ovf   (dp_ovf)
  );

  // abort blocks acceptance in the same cycle, so an abort never races a beat.
  assign in_ready = (state_reg == ST_ACC) && !abort;
  assign beat     = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // State register and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_reg     <= ST_IDLE;
      remaining_reg <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      sum_reg       <= sum_next;
      carry_reg     <= carry_next;
      ovf_reg       <= ovf_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and register-update logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    sum_next       = sum_reg;
    carry_next     = carry_reg;
    ovf_next       = ovf_reg;

    unique case (state_reg)
      ST_IDLE: begin
        // abort alongside start suppresses the start.
        if (start && !abort) begin
          sum_next       = '0;
          carry_next     = 1'b0;
          ovf_next       = 1'b0;
          remaining_next = len;
          // An empty run completes immediately without consuming operands.
          if (len == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_ACC;
          end
        end
      end

      ST_ACC: begin
        if (abort) begin
          // Partial sum and flags are left visible after a cancel.
          state_next = ST_IDLE;
        end else if (beat) begin
          sum_next       = dp_sum;
          carry_next     = carry_reg | dp_carry;
          ovf_next       = ovf_reg | dp_ovf;
          remaining_next = remaining_reg - 1'b1;
          if (remaining_reg == CW'(1)) begin
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // DONE lasts one cycle whether or not abort is present.
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign sum        = sum_reg;
  assign carry_flag = carry_reg;
  assign ovf_flag   = ovf_reg;
  assign done       = (state_reg == ST_DONE);
  assign busy       = (state_reg != ST_IDLE);

endmodule : accum_seq_ctrl
